// File: rtl/filter_axis_packer.sv
// Rounds, scales and saturates biquad output samples, buffers them in a
// show-ahead FIFO and presents them as an AXI-Stream with frame-based tlast.
module filter_axis_packer #(
  parameter int IN_W       = 46,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 14,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_data_valid,
  input  logic [IN_W-1:0]               in_data,
  input  logic [31:0]                   config_reg,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          sat_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = IN_W + 1;

  localparam logic signed [SW-1:0] RND_C   = {{(SW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [LW-1:0]        FULL_LVL = LW'(FIFO_DEPTH);

  logic                     flush;
  logic [15:0]              cfg_len;
  logic                     unused_cfg;

  logic signed [SW-1:0]     sum_ext;
  logic signed [SW-1:0]     shifted;
  logic [OUT_W-1:0]         s1_res;
  logic                     clamp;
  logic                     capture;

  logic                     s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]         s1_data_q, s1_data_d;
  logic                     sat_flag_q, sat_flag_d;

  logic [OUT_W-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic [15:0]              ovf_q, ovf_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [15:0]              len_q, len_d;
  logic [15:0]              cur_len;

  logic                     full;
  logic                     pop;
  logic                     wr_req;
  logic                     wr_en;
  logic                     drop;

  assign flush      = config_reg[31];
  assign cfg_len    = config_reg[15:0];
  assign unused_cfg = ^config_reg[30:16];

  // Rounding add is one bit wider than the input so it can never wrap.
  always_comb begin
    sum_ext = $signed({in_data[IN_W-1], in_data}) + RND_C;
    shifted = sum_ext >>> FRAC_SHIFT;
    clamp   = 1'b0;
    s1_res  = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      s1_res = SAT_MAX[OUT_W-1:0];
      clamp  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      s1_res = SAT_MIN[OUT_W-1:0];
      clamp  = 1'b1;
    end
  end

  assign capture = in_data_valid && !flush;

  assign full          = (level_q == FULL_LVL);
  assign m_axis_tvalid = (level_q != '0) && !flush;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign wr_req        = s1_valid_q && !flush;
  // A write into a full FIFO survives only if the head is leaving this cycle.
  assign wr_en         = wr_req && (!full || pop);
  assign drop          = wr_req && full && !pop;

  // At count 0 the frame length comes straight from config so a new frame
  // sees the current setting on its first beat.
  assign cur_len      = (cnt_q == 16'd0) ? cfg_len : len_q;
  assign m_axis_tlast = m_axis_tvalid && (cur_len != 16'd0) && (cnt_q == cur_len - 16'd1);
  assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr_q] : '0;

  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign sat_flag       = sat_flag_q;

  always_comb begin
    s1_valid_d = capture;
    s1_data_d  = capture ? s1_res : s1_data_q;
    sat_flag_d = sat_flag_q | (capture & clamp);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = 16'd0;
      len_d    = cfg_len;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_d = ovf_q + 16'd1;
      end
      if (cnt_q == 16'd0) begin
        len_d = cfg_len;
      end
      if (pop) begin
        if ((cur_len == 16'd0) || m_axis_tlast) begin
          cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_flag_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 16'd0;
      cnt_q      <= 16'd0;
      len_q      <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sat_flag_q <= sat_flag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s1_data_q;
    end
  end

endmodule

// File: tb/tb_filter_axis_packer.sv
// Scoreboard bench for filter_axis_packer: stimulus feeds a queue-based reference
// model, a negedge monitor pops expected beats and compares every DUT output.
module tb_filter_axis_packer;

  localparam int IN_W       = 46;
  localparam int OUT_W      = 32;
  localparam int FRAC_SHIFT = 14;
  localparam int DEPTH      = 16;

  logic              clk;
  logic              rst;
  logic              in_data_valid;
  logic [IN_W-1:0]   in_data;
  logic [31:0]       config_reg;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]       overflow_count;
  logic              sat_flag;

  filter_axis_packer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_data_valid(in_data_valid), .in_data(in_data),
    .config_reg(config_reg), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .fifo_level(fifo_level),
    .overflow_count(overflow_count), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference state: sample in flight, expected FIFO contents, counters.
  logic [OUT_W-1:0] exp_q[$];
  bit               pend_v = 1'b0;
  logic [OUT_W-1:0] pend_d = '0;
  int               m_ovf = 0;
  bit               m_sat = 1'b0;
  int               m_cnt = 0;
  int               m_len = 0;

  logic [OUT_W-1:0] log_d[$];
  bit               log_l[$];
  int               log_c[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_sample(input longint x, output bit clamped);
    longint r, hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    r  = (x + (longint'(1) <<< (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
    clamped = 1'b0;
    if (r > hi) begin
      r = hi;
      clamped = 1'b1;
    end else if (r < lo) begin
      r = lo;
      clamped = 1'b1;
    end
    return r[OUT_W-1:0];
  endfunction

  // One clock: apply the model's view of this edge, then step off the edge.
  task automatic tick();
    bit cl;
    longint x;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      pend_v = 1'b0;
      m_ovf  = 0;
      m_sat  = 1'b0;
    end else if (config_reg[31]) begin
      exp_q.delete();
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        if (exp_q.size() == DEPTH) begin
          if (m_ovf < 16'hFFFF) m_ovf++;
        end else begin
          exp_q.push_back(pend_d);
        end
      end
      pend_v = in_data_valid;
      if (in_data_valid) begin
        x = longint'($signed(in_data));
        pend_d = ref_sample(x, cl);
        if (cl) m_sat = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send(input longint v);
    in_data       = v[IN_W-1:0];
    in_data_valid = 1'b1;
    tick();
    in_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_flush();
    config_reg[31] = 1'b1;
    tick();
    config_reg[31] = 1'b0;
  endtask

  task automatic drain_random(input string name);
    int budget;
    budget = 400;
    while ((exp_q.size() != 0 || pend_v) && budget > 0) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    m_axis_tready = 1'b1;
    chk(name, 64'(budget == 0), 64'd0);
  endtask

  // Monitor: compares every cycle at the falling edge and retires popped beats.
  initial begin
    bit exp_valid, exp_last;
    int cur_len;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cnt = 0;
      end else begin
        exp_valid = (exp_q.size() != 0) && !config_reg[31];
        chk("tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("overflow_count", 64'(overflow_count), 64'(m_ovf));
        chk("sat_flag", 64'(sat_flag), 64'(m_sat));
        if (config_reg[31]) begin
          m_cnt = 0;
        end else if (exp_valid) begin
          cur_len  = (m_cnt == 0) ? int'(config_reg[15:0]) : m_len;
          exp_last = (cur_len != 0) && (m_cnt == cur_len - 1);
          chk("tdata", 64'(m_axis_tdata), 64'(exp_q[0]));
          chk("tlast", 64'(m_axis_tlast), 64'(exp_last));
          if (m_axis_tready) begin
            log_d.push_back(m_axis_tdata);
            log_l.push_back(m_axis_tlast);
            log_c.push_back(cyc);
            void'(exp_q.pop_front());
            if (m_cnt == 0) m_len = cur_len;
            if (cur_len == 0 || exp_last) m_cnt = 0;
            else m_cnt++;
          end
        end else begin
          chk("tlast_idle", 64'(m_axis_tlast), 64'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OUT_W-1:0] rnd_exp [5];
    longint rnd_in [5];
    int base;
    longint v;

    rnd_in  = '{64'sd16384, 64'sd8192, 64'sd8191, -64'sd8192, -64'sd8193};
    rnd_exp = '{32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};

    rst = 1'b1; in_data_valid = 1'b0; in_data = '0; config_reg = 32'd0; m_axis_tready = 1'b1;
    idle(2);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow_count), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    rst = 1'b0;
    idle(2);

    // Rounding and latency.
    base = log_d.size();
    send(rnd_in[0]);
    chk("latency_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(rnd_in[1]);
    chk("latency_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("latency_n2_tdata", 64'(m_axis_tdata), 64'd1);
    for (int i = 2; i < 5; i++) send(rnd_in[i]);
    idle(5);
    chk("round_beats", 64'(log_d.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("round_%0d", i), 64'(log_d[base+i]), 64'(rnd_exp[i]));
    chk("round_sat", 64'(sat_flag), 64'd0);

    // Saturation, sticky flag.
    base = log_d.size();
    send((longint'(1) <<< 45) - 1);
    send(-(longint'(1) <<< 45));
    for (int i = 0; i < 10; i++) send(longint'($urandom_range(0, 5000)) - 2500);
    idle(6);
    chk("sat_pos", 64'(log_d[base]), 64'h7FFF_FFFF);
    chk("sat_neg", 64'(log_d[base+1]), 64'h8000_0000);
    chk("sat_sticky", 64'(sat_flag), 64'd1);

    // Overflow with stalled sink, then gapless drain.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 20; i++) send(longint'(i) << 14);
    idle(2);
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_count", 64'(overflow_count), 64'd4);
    base = log_d.size();
    m_axis_tready = 1'b1;
    idle(20);
    chk("ovf_drain_beats", 64'(log_d.size() - base), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_drain_%0d", i), 64'(log_d[base+i]), 64'(i + 1));
    chk("ovf_drain_gap", 64'(log_c[base+15] - log_c[base]), 64'd15);

    // Full FIFO: write and pop land on the same edge.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 16; i++) send(longint'(i + 100) << 14);
    idle(2);
    in_data = IN_W'(longint'(999) << 14); in_data_valid = 1'b1;
    tick();
    in_data_valid = 1'b0; m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    tick();
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_ovf", 64'(overflow_count), 64'd4);
    m_axis_tready = 1'b1;
    idle(20);

    // Framing, steady ready then random ready.
    config_reg[15:0] = 16'd4;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_flush();
      base = log_l.size();
      for (int i = 1; i <= 10; i++) begin
        if (pass == 1) m_axis_tready = 1'($urandom_range(0, 1));
        send(longint'(i) << 14);
      end
      drain_random($sformatf("frame_drain_timeout_%0d", pass));
      idle(3);
      chk($sformatf("frame_beats_%0d", pass), 64'(log_l.size() - base), 64'd10);
      for (int k = 0; k < 10; k++)
        chk($sformatf("frame%0d_tlast_%0d", pass, k), 64'(log_l[base+k]), 64'(k == 3 || k == 7));
    end

    // Mid-frame flush, then the same with reset.
    for (int pass = 0; pass < 2; pass++) begin
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 5; i++) send(longint'(i) << 14);
      idle(2);
      m_axis_tready = 1'b1;
      idle(2);
      m_axis_tready = 1'b0;
      if (pass == 0) begin
        pulse_flush();
      end else begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ovf", 64'(overflow_count), 64'd0);
        chk("rst_mid_sat", 64'(sat_flag), 64'd0);
      end
      chk($sformatf("midflush_tvalid_%0d", pass), 64'(m_axis_tvalid), 64'd0);
      chk($sformatf("midflush_level_%0d", pass), 64'(fifo_level), 64'd0);
      m_axis_tready = 1'b1;
      base = log_l.size();
      for (int i = 1; i <= 4; i++) send(longint'(i + 50) << 14);
      idle(5);
      chk($sformatf("midflush_beats_%0d", pass), 64'(log_l.size() - base), 64'd4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("midflush%0d_tlast_%0d", pass, k), 64'(log_l[base+k]), 64'(k == 3));
    end

    // Randomized traffic with occasional flush and frame-length changes.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        config_reg[15:0] = 16'($urandom_range(0, 5));
        pulse_flush();
      end else begin
        v = longint'({$urandom, $urandom}) >>> (18 + $urandom_range(0, 40));
        in_data       = v[IN_W-1:0];
        in_data_valid = ($urandom_range(0, 9) < 6);
        m_axis_tready = ($urandom_range(0, 9) < 7);
        tick();
        in_data_valid = 1'b0;
      end
    end
    drain_random("random_drain_timeout");
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
